// File: rtl/nes_cpu_bus.sv
// nes_cpu_bus: NES CPU-side memory map responder with work RAM, PPU/PRG decode, OAM DMA and controller port
//   clk, rst                       : clock, synchronous active-high reset
//   cpu_mem_addr/data_out/data_in  : CPU address, write data, registered read data
//   cpu_write_en/read_en/halt      : CPU strobes and DMA stall
//   ppu_reg_*                      : PPU register port ($2000-$3FFF mirrored)
//   prg_*                          : cartridge PRG port ($8000-$FFFF)
//   oam_*                          : OAM write port driven by DMA
//   joy1_buttons, ctrl_strobe      : controller 1 parallel buttons and latch strobe
module nes_cpu_bus #(
   parameter int          RAM_BYTES = 2048,
   parameter logic [15:0] DMA_REG   = 16'h4014,
   parameter logic [15:0] JOY_REG   = 16'h4016
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_mem_addr,
   input  logic [7:0]  cpu_data_out,
   output logic [7:0]  cpu_data_in,
   input  logic        cpu_write_en,
   input  logic        cpu_read_en,
   output logic        cpu_halt,
   output logic [2:0]  ppu_reg_addr,
   output logic [7:0]  ppu_reg_wdata,
   output logic        ppu_reg_we,
   output logic        ppu_reg_re,
   input  logic [7:0]  ppu_reg_rdata,
   output logic [14:0] prg_addr,
   output logic        prg_re,
   input  logic [7:0]  prg_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_we,
   input  logic [7:0]  joy1_buttons,
   output logic        ctrl_strobe
);
   localparam int AW = $clog2(RAM_BYTES);
   typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;
   state_t state, state_nx;
   logic [7:0] ram [RAM_BYTES];
   logic [7:0] page, idx, open_bus, shreg, rdata;
   logic [15:0] a;
   logic parity, align_wait, rd, wr, in_ram, in_ppu, in_prg, in_joy, in_dma;
   assign cpu_halt = state != IDLE;
   // while halted the DMA engine owns the bus and the CPU strobes are ignored
   assign a = cpu_halt ? {page, idx} : cpu_mem_addr;
   assign rd = cpu_halt ? state == READ : cpu_read_en & ~cpu_write_en;
   assign wr = ~cpu_halt & cpu_write_en;
   assign in_ram = a[15:13] == 3'b000;
   assign in_ppu = a[15:13] == 3'b001;
   assign in_prg = a[15];
   assign in_joy = a == JOY_REG;
   assign in_dma = a == DMA_REG;
   assign ppu_reg_addr = a[2:0];
   assign ppu_reg_wdata = cpu_data_out;
   assign ppu_reg_we = in_ppu & wr;
   assign ppu_reg_re = in_ppu & rd;
   assign prg_addr = a[14:0];
   assign prg_re = in_prg & rd;
   assign rdata = in_ram ? ram[a[AW-1:0]] :
                  in_ppu ? ppu_reg_rdata :
                  in_prg ? prg_rdata :
                  in_joy ? {7'b0100000, shreg[0]} : open_bus;
   always_ff @(posedge clk) begin
      if (wr && in_ram) ram[a[AW-1:0]] <= cpu_data_out;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (wr && in_dma) state_nx = ALIGN;
         ALIGN:   if (!align_wait) state_nx = READ;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = idx == 8'hFF ? IDLE : READ;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cpu_data_in <= 8'h00;
         open_bus <= 8'h00;
         oam_we <= 1'b0;
         oam_addr <= 8'h00;
         oam_wdata <= 8'h00;
         ctrl_strobe <= 1'b0;
         shreg <= 8'hFF;
         parity <= 1'b0;
         page <= 8'h00;
         idx <= 8'h00;
         align_wait <= 1'b0;
      end else begin
         state <= state_nx;
         parity <= ~parity;
         oam_we <= state == READ;
         if (rd) open_bus <= rdata;
         if (rd && !cpu_halt) cpu_data_in <= rdata;
         if (state == READ) begin
            oam_wdata <= rdata;
            oam_addr <= idx;
         end
         if (state == WRITE) idx <= idx + 8'd1;
         if (state == ALIGN) align_wait <= 1'b0;
         // odd parity at the trigger edge costs one extra alignment cycle
         if (wr && in_dma) begin
            page <= cpu_data_out;
            idx <= 8'h00;
            align_wait <= parity;
         end
         if (wr && in_joy) ctrl_strobe <= cpu_data_out[0];
         shreg <= ctrl_strobe ? joy1_buttons :
                  (rd && !cpu_halt && in_joy) ? {1'b1, shreg[7:1]} : shreg;
      end
   end
endmodule
